// File: rtl/sv32_page_walker.sv
// Sv32 data-side hardware page-table walker: fetches one or two PTEs over a
// single-outstanding read port and returns the leaf PTE or a fault cause.
module sv32_page_walker #(
    parameter logic [3:0] PAGE_FAULT_LD   = 4'd13,
    parameter logic [3:0] PAGE_FAULT_ST   = 4'd15,
    parameter logic [3:0] ACCESS_FAULT_LD = 4'd5,
    parameter logic [3:0] ACCESS_FAULT_ST = 4'd7
) (
    input  logic        cpu_clk_i,
    input  logic        cpu_rst_ni,
    input  logic        flush_i,
    input  logic [19:0] satp_ppn_i,
    input  logic [19:0] vpn_i,
    input  logic        vpn_vld_i,
    input  logic        isWrite_i,
    output logic        walker_busy_o,
    output logic        resp_vld_o,
    output logic        is_superpage_o,
    output logic [31:0] assoc_pte_o,
    output logic [3:0]  excp_code_o,
    output logic        excp_vld_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);
    typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP, DRAIN} state_t;
    typedef enum logic [1:0] {CHK_LEAF, CHK_NEXT, CHK_PF, CHK_AF} chk_t;

    state_t     state;
    logic [9:0] vpn_lo_q;
    logic       wr_q;
    chk_t       pte_res;
    logic       fault;
    logic [3:0] fault_code;

    // PTE bits: 0 V, 1 R, 2 W, 3 X, 6 A, 7 D; PPN[0] sits in [19:10].
    function automatic chk_t pte_check(input logic [31:0] pte, input logic wr, input logic lvl1);
        chk_t res;
        if (pte[31:30] != 2'b00)
            res = CHK_AF;
        else if (!pte[0] || (!pte[1] && pte[2]))
            res = CHK_PF;
        else if (pte[1] || pte[3]) begin
            if (lvl1 && pte[19:10] != 10'd0)
                res = CHK_PF;
            else if (!pte[6] || (wr && !pte[7]))
                res = CHK_PF;
            else
                res = CHK_LEAF;
        end else
            res = lvl1 ? CHK_NEXT : CHK_PF;
        return res;
    endfunction

    always_comb begin
        pte_res = pte_check(mem_rdata_i, wr_q, state == L1_WAIT);
        fault   = mem_err_i || (pte_res == CHK_PF) || (pte_res == CHK_AF);
        if (mem_err_i || pte_res == CHK_AF)
            fault_code = wr_q ? ACCESS_FAULT_ST : ACCESS_FAULT_LD;
        else
            fault_code = wr_q ? PAGE_FAULT_ST : PAGE_FAULT_LD;
    end

    assign walker_busy_o = (state != IDLE);

    always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
        if (!cpu_rst_ni) begin
            state          <= IDLE;
            vpn_lo_q       <= '0;
            wr_q           <= 1'b0;
            mem_req_o      <= 1'b0;
            mem_addr_o     <= '0;
            resp_vld_o     <= 1'b0;
            excp_vld_o     <= 1'b0;
            excp_code_o    <= '0;
            assoc_pte_o    <= '0;
            is_superpage_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (vpn_vld_i && !flush_i) begin
                    vpn_lo_q   <= vpn_i[9:0];
                    wr_q       <= isWrite_i;
                    mem_req_o  <= 1'b1;
                    mem_addr_o <= {satp_ppn_i, vpn_i[19:10], 2'b00};
                    state      <= L1_REQ;
                end
                L1_REQ, L0_REQ: begin
                    // A grant in the flush cycle still leaves a read in flight.
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        if (flush_i)
                            state <= DRAIN;
                        else
                            state <= (state == L1_REQ) ? L1_WAIT : L0_WAIT;
                    end else if (flush_i) begin
                        mem_req_o <= 1'b0;
                        state     <= IDLE;
                    end
                end
                L1_WAIT, L0_WAIT: begin
                    if (mem_rvalid_i) begin
                        if (flush_i)
                            state <= IDLE;
                        else if (!mem_err_i && pte_res == CHK_NEXT) begin
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= {mem_rdata_i[29:10], vpn_lo_q, 2'b00};
                            state      <= L0_REQ;
                        end else begin
                            resp_vld_o     <= 1'b1;
                            excp_vld_o     <= fault;
                            excp_code_o    <= fault ? fault_code : 4'd0;
                            assoc_pte_o    <= mem_err_i ? 32'd0 : mem_rdata_i;
                            is_superpage_o <= !fault && (state == L1_WAIT);
                            state          <= RESP;
                        end
                    end else if (flush_i)
                        state <= DRAIN;
                end
                RESP: begin
                    resp_vld_o <= 1'b0;
                    excp_vld_o <= 1'b0;
                    state      <= IDLE;
                end
                DRAIN: if (mem_rvalid_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
